// File: rtl/sound_voice_sched.sv
// sound_voice_sched: shares one 8-bit sample ROM read port among VOICES
// sample voices. Once per sample tick it fetches one byte per active voice,
// mixes all voices into an unsigned 16-bit sample and strobes it out.
// Silent voices contribute the mid-scale value 8'h80.
// Build option: define SOUND_SCHED_LOOP_EN to honor the per-voice loop input.
// Without it, every voice is one-shot and loop is ignored.
module sound_voice_sched #(
    parameter int VOICES  = 4,
    parameter int ADDR_W  = 16,
    parameter int DIV     = 3000,
    parameter int ROM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [VOICES-1:0]        trig,
    input  logic [VOICES-1:0]        stop,
    input  logic [VOICES*ADDR_W-1:0] start_addr,
    input  logic [VOICES*ADDR_W-1:0] length,
    input  logic [VOICES-1:0]        loop,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     rom_rd,
    input  logic [7:0]               rom_data,
    output logic [VOICES-1:0]        busy,
    output logic [VOICES-1:0]        done,
    output logic [15:0]              audio,
    output logic                     audio_strobe,
    output logic [2:0]               state_dbg
);
    localparam int LV = $clog2(VOICES);
    localparam int AW = 8 + LV;
    localparam int CW = $clog2(DIV);
    localparam int WW = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        WAIT = 3'd2,
        MIX  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     pre_cnt;
    logic              tick;
    logic [LV-1:0]     v;
    logic [AW-1:0]     acc;
    logic [WW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base      [VOICES];
    logic [ADDR_W-1:0] len       [VOICES];
    logic [ADDR_W-1:0] pos       [VOICES];
    logic [ADDR_W-1:0] pend_base [VOICES];
    logic [ADDR_W-1:0] pend_len  [VOICES];
    logic [VOICES-1:0] pend_trig;
    logic [VOICES-1:0] pend_stop;
    logic [VOICES-1:0] loop_en;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_smp;

`ifdef SOUND_SCHED_LOOP_EN
    assign loop_en = loop;
`else
    logic loop_unused;
    assign loop_en     = '0;
    assign loop_unused = ^loop;
`endif

    assign tick      = (pre_cnt == CW'(DIV - 1));
    assign cur_addr  = base[v] + pos[v];
    assign last_smp  = (({1'b0, pos[v]} + (ADDR_W+1)'(1)) >= {1'b0, len[v]});
    assign state_dbg = state;

    // ROM port: address is live while a fetch is issued, otherwise holds the last fetch address
    assign rom_rd   = (state == SCAN) && busy[v];
    assign rom_addr = rom_rd ? cur_addr : addr_q;

    // done pulses during the MIX cycle that consumes a one-shot voice's final sample
    always_comb begin
        done = '0;
        if (state == MIX && last_smp && !loop_en[v])
            done[v] = 1'b1;
    end

    // Sample-rate prescaler: tick on the last count of every DIV-cycle period
    always_ff @(posedge clk) begin
        if (reset || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // Capture trig/stop requests and the trig parameters until the next tick applies them
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_trig <= '0;
            pend_stop <= '0;
            for (int i = 0; i < VOICES; i++) begin
                pend_base[i] <= '0;
                pend_len[i]  <= '0;
            end
        end else begin
            if (tick) begin
                pend_trig <= trig;
                pend_stop <= stop;
            end else begin
                pend_trig <= pend_trig | trig;
                pend_stop <= pend_stop | stop;
            end
            for (int i = 0; i < VOICES; i++) begin
                if (trig[i]) begin
                    pend_base[i] <= start_addr[i*ADDR_W +: ADDR_W];
                    pend_len[i]  <= length[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Scan FSM: apply requests on tick, fetch and mix each voice in turn, publish the sample
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            v            <= '0;
            acc          <= '0;
            wait_cnt     <= '0;
            addr_q       <= '0;
            busy         <= '0;
            audio        <= 16'h8000;
            audio_strobe <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                base[i] <= '0;
                len[i]  <= '0;
                pos[i]  <= '0;
            end
        end else begin
            audio_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        // stop beats trig; a zero-length trig is dropped entirely
                        for (int i = 0; i < VOICES; i++) begin
                            if (pend_stop[i]) begin
                                busy[i] <= 1'b0;
                            end else if (pend_trig[i] && pend_len[i] != '0) begin
                                busy[i] <= 1'b1;
                                pos[i]  <= '0;
                                base[i] <= pend_base[i];
                                len[i]  <= pend_len[i];
                            end
                        end
                        acc   <= '0;
                        v     <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (busy[v]) begin
                        addr_q <= cur_addr;
                        if (ROM_LAT > 1) begin
                            wait_cnt <= WW'(ROM_LAT - 2);
                            state    <= WAIT;
                        end else begin
                            state <= MIX;
                        end
                    end else begin
                        acc <= acc + AW'(8'h80);
                        if (v == LV'(VOICES - 1))
                            state <= OUT;
                        else
                            v <= v + 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0)
                        state <= MIX;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                MIX: begin
                    acc <= acc + AW'(rom_data);
                    if (!last_smp)
                        pos[v] <= pos[v] + 1'b1;
                    else if (loop_en[v])
                        pos[v] <= '0;
                    else
                        busy[v] <= 1'b0;
                    if (v == LV'(VOICES - 1)) begin
                        state <= OUT;
                    end else begin
                        v     <= v + 1'b1;
                        state <= SCAN;
                    end
                end
                OUT: begin
                    audio        <= 16'(acc) << (8 - LV);
                    audio_strobe <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sound_voice_sched.sv
// Bench for sound_voice_sched: directed scenarios plus random trig/stop/loop
// traffic, checked against a per-tick voice model and a fetch-address queue.
module tb_sound_voice_sched;
    localparam int V   = 4;
    localparam int AW  = 16;
    localparam int DIV = 40;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [V-1:0]    trig, stop, loop;
    logic [V*AW-1:0] start_addr, length;
    logic [AW-1:0]   rom_addr;
    logic            rom_rd;
    logic [7:0]      rom_data;
    logic [V-1:0]    busy, done;
    logic [15:0]     audio;
    logic            audio_strobe;
    logic [2:0]      state_dbg;

    logic [7:0]      rom_mem [0:65535];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int k_tick = 0;

    // scoreboard
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] obs_q[$];
    logic [V-1:0]  done_obs;
    logic [15:0]   last_audio;

    // model state
    logic [V-1:0] m_busy;
    int           m_base [V];
    int           m_len  [V];
    int           m_pos  [V];
    bit           m_pt   [V];
    bit           m_ps   [V];
    int           m_pb   [V];
    int           m_pl   [V];

    sound_voice_sched #(.VOICES(V), .ADDR_W(AW), .DIV(DIV), .ROM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .trig(trig), .stop(stop),
        .start_addr(start_addr), .length(length), .loop(loop),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .busy(busy), .done(done), .audio(audio), .audio_strobe(audio_strobe),
        .state_dbg(state_dbg)
    );

    // clock and one-cycle-latency ROM
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock; sample outputs on the falling edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rom_rd) obs_q.push_back(rom_addr);
        done_obs = done_obs | done;
    endtask

    function automatic bit model_loop(input int i);
`ifdef SOUND_SCHED_LOOP_EN
        return loop[i];
`else
        return 1'b0;
`endif
    endfunction

    task automatic fire_trig(input int vi, input int b, input int l);
        start_addr[vi*AW +: AW] = AW'(b);
        length[vi*AW +: AW]     = AW'(l);
        trig[vi] = 1'b1;
        step();
        trig = '0;
        m_pt[vi] = 1'b1;
        m_pb[vi] = b;
        m_pl[vi] = l;
    endtask

    task automatic fire_stop(input int vi);
        stop[vi] = 1'b1;
        step();
        stop = '0;
        m_ps[vi] = 1'b1;
    endtask

    task automatic clear_model();
        m_busy = '0;
        for (int i = 0; i < V; i++) begin
            m_base[i] = 0; m_len[i] = 0; m_pos[i] = 0;
            m_pt[i] = 0; m_ps[i] = 0; m_pb[i] = 0; m_pl[i] = 0;
        end
    endtask

    // Apply pending requests to the model, predict one sample, then observe it.
    task automatic run_tick(input string tag);
        int s;
        int sum;
        int lim;
        bit got;
        logic [V-1:0]  exp_done;
        logic [AW-1:0] a;
        logic [15:0]   exp_audio;
        k_tick++;
        for (int i = 0; i < V; i++) begin
            if (m_ps[i]) begin
                m_busy[i] = 1'b0;
            end else if (m_pt[i] && m_pl[i] != 0) begin
                m_busy[i] = 1'b1;
                m_pos[i]  = 0;
                m_base[i] = m_pb[i];
                m_len[i]  = m_pl[i];
            end
            m_pt[i] = 0;
            m_ps[i] = 0;
        end
        s = V;
        sum = 0;
        exp_done = '0;
        for (int i = 0; i < V; i++) begin
            if (m_busy[i]) begin
                a = AW'(m_base[i] + m_pos[i]);
                exp_q.push_back(a);
                sum += int'(rom_mem[a]);
                s++;
                if (m_pos[i] + 1 < m_len[i]) m_pos[i]++;
                else if (model_loop(i)) m_pos[i] = 0;
                else begin
                    m_busy[i] = 1'b0;
                    exp_done[i] = 1'b1;
                end
            end else begin
                sum += 128;
            end
        end
        exp_audio = 16'(sum * 64);
        got = 0;
        lim = k_tick * DIV + s + 8;
        while (!got && cyc < lim) begin
            step();
            if (audio_strobe) got = 1;
        end
        chk({tag, ":strobe_seen"}, 32'(got), 32'd1);
        chk({tag, ":strobe_cycle"}, 32'(cyc), 32'(k_tick * DIV + 1 + s));
        chk({tag, ":audio"}, 32'(audio), 32'(exp_audio));
        chk({tag, ":done"}, 32'(done_obs), 32'(exp_done));
        chk({tag, ":busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ":fetch_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk({tag, ":fetch_addr"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
        done_obs = '0;
        last_audio = audio;
    endtask

    initial begin
        bit found;
        trig = '0; stop = '0; loop = '0;
        start_addr = '0; length = '0;
        done_obs = '0;
        last_audio = '0;
        clear_model();
        for (int i = 0; i < 65536; i++) rom_mem[i] = 8'($urandom_range(0, 255));
        rom_mem[16'h0100] = 8'h00;
        rom_mem[16'h0101] = 8'hFF;
        rom_mem[16'h0102] = 8'h80;

        // reset values
        repeat (3) step();
        chk("rst:audio", 32'(audio), 32'h8000);
        chk("rst:strobe", 32'(audio_strobe), 32'd0);
        chk("rst:rom_rd", 32'(rom_rd), 32'd0);
        chk("rst:rom_addr", 32'(rom_addr), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        cyc = 0;
        obs_q.delete();
        done_obs = '0;

        // idle: silence at mid-scale, no fetches
        run_tick("idle0");
        run_tick("idle1");
        chk("idle:audio_const", 32'(last_audio), 32'h8000);

        // one-shot voice 0, three bytes
        fire_trig(0, 16'h0100, 3);
        run_tick("os0");
        chk("os0:audio_const", 32'(last_audio), 32'h6000);
        run_tick("os1");
        chk("os1:audio_const", 32'(last_audio), 32'h9FC0);
        run_tick("os2");
        chk("os2:audio_const", 32'(last_audio), 32'h8000);
        chk("os2:busy0", 32'(busy[0]), 32'd0);

        // looping voice 1 (one-shot when looping is not built in)
        loop = 4'b0010;
        fire_trig(1, 16'h2000, 2);
        for (int t = 0; t < 6; t++) run_tick("loop");
        fire_stop(1);
        run_tick("loop_stop");
        loop = '0;

        // trig+stop together, zero-length trig
        fire_trig(2, 16'h3000, 4);
        fire_stop(2);
        fire_trig(3, 16'h4000, 0);
        run_tick("simul");
        chk("simul:busy23", 32'(busy[3:2]), 32'd0);

        // restart of a busy voice
        fire_trig(0, 16'h0400, 5);
        run_tick("rs0");
        run_tick("rs1");
        fire_trig(0, 16'h0500, 3);
        run_tick("rs2");

        // address wrap-around
        fire_stop(0);
        fire_trig(1, 16'hFFFF, 2);
        run_tick("wrap0");
        run_tick("wrap1");

        // random traffic
        for (int t = 0; t < 16; t++) begin
            loop = 4'($urandom_range(0, 15));
            for (int i = 0; i < V; i++) begin
                case ($urandom_range(0, 3))
                    0: fire_trig(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 5)));
                    1: fire_stop(i);
                    default: ;
                endcase
            end
            run_tick("rand");
        end
        loop = '0;

        // reset in the middle of a scan, during voice 1's fetch
        fire_trig(0, 16'h0200, 4);
        fire_trig(1, 16'h0300, 4);
        found = 0;
        for (int i = 0; i < 2 * DIV && !found; i++) begin
            step();
            if (rom_rd && rom_addr == 16'h0300) found = 1;
        end
        chk("mid_rst:fetch_seen", 32'(found), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst:busy", 32'(busy), 32'd0);
        chk("mid_rst:audio", 32'(audio), 32'h8000);
        chk("mid_rst:state", 32'(state_dbg), 32'd0);
        chk("mid_rst:rom_rd", 32'(rom_rd), 32'd0);
        chk("mid_rst:rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_rst:strobe", 32'(audio_strobe), 32'd0);
        reset = 1'b0;
        cyc = 0;
        k_tick = 0;
        clear_model();
        exp_q.delete();
        obs_q.delete();
        done_obs = '0;
        run_tick("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sound_voice_sched.md
# sound_voice_sched

- Time-multiplexes the single 8-bit sample ROM read port across VOICES one-shot or looping sample voices.
- On every sample tick it fetches one byte per active voice and mixes the bytes into one unsigned 16-bit sample for AUDIO_L/AUDIO_R.
- It sits between the ROM's port b and the audio outputs, and replaces the per-player ROM access of the wav playback path.

## Interface
Parameters:
- VOICES, 4: number of voices; power of two, 2..8
- ADDR_W, 16: ROM address width
- DIV, 3000: clk cycles per sample tick (8 kHz at 24 MHz); must exceed VOICES*(ROM_LAT+1)+2
- ROM_LAT, 1: cycles from rom_addr to valid rom_data

Ports:
- clk  in  1  system clock; one clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- trig  in  VOICES  one-cycle pulse per voice: start playback
- stop  in  VOICES  one-cycle pulse per voice: stop playback
- start_addr  in  VOICES*ADDR_W  per-voice base address, voice v at [v*ADDR_W +: ADDR_W]
- length  in  VOICES*ADDR_W  per-voice sample count, same packing
- loop  in  VOICES  per-voice loop enable
- rom_addr  out  ADDR_W  ROM read address
- rom_rd  out  1  high on each cycle a fetch address is issued
- rom_data  in  8  ROM read data, unsigned
- busy  out  VOICES  voice active
- done  out  VOICES  one-cycle pulse when a one-shot voice ends
- audio  out  16  mixed unsigned sample
- audio_strobe  out  1  one-cycle pulse on each audio update

## Operation
Prescaler:
- Counts 0..DIV-1 and wraps.
- A tick occurs on the cycle the count equals DIV-1.

trig/stop capture:
- trig[v] and stop[v] are latched into pending bits on any cycle.
- trig also latches start_addr[v] and length[v] into voice registers.
- Pending bits are applied only on the tick cycle.

Tick cycle:
- Apply pending bits to busy. When trig and stop are both pending for a voice, stop wins.
- A trig with length 0 is dropped; busy stays 0.
- An applied trig sets pos[v]=0 and busy[v]=1, including when the voice is already busy (restart).
- Clear pending bits, load the accumulator with 0, set v=0, and go to SCAN.

FSM states: IDLE, SCAN, WAIT, MIX, OUT.
- IDLE: wait for tick; on tick go to SCAN.
- SCAN, busy[v]=1:
  - Drive rom_addr = base[v] + pos[v], modulo 2^ADDR_W; wrap-around is legal.
  - Drive rom_rd=1 and go to WAIT.
- SCAN, busy[v]=0:
  - Add 8'h80 to the accumulator.
  - If v<VOICES-1, stay in SCAN with v+1; otherwise go to OUT.
- WAIT: hold for ROM_LAT-1 further cycles, then go to MIX.
- MIX:
  - Add the zero-extended rom_data to the accumulator.
  - Advance the voice:
    - If pos+1 < length: pos+1.
    - Else if loop=1: pos=0.
    - Else: busy=0 and pulse done[v].
  - Then go to SCAN with v+1, or to OUT if v was VOICES-1.
- OUT:
  - audio <= acc << (8 - log2(VOICES)), where acc is 8+log2(VOICES) bits wide.
  - Pulse audio_strobe and go to IDLE.
- All-silent output is exactly 16'h8000.
- stop or trig arriving mid-scan cannot change the current scan; it takes effect at the next tick.
- length and start_addr changes with no trig have no effect on a playing voice.

## Timing
Reset values:
- audio = 16'h8000
- audio_strobe, rom_rd, busy, done, pending = 0
- rom_addr = 0
- prescaler = 0; FSM in IDLE

First tick is at cycle DIV-1 after reset deasserts.

Per-voice scan cost:
- Active voice: 1 + ROM_LAT cycles (SCAN, WAIT, MIX merged when ROM_LAT=1: 2 cycles).
- Inactive voice: 1 cycle.

audio and audio_strobe update at tick + 1 + S, where S is the sum of the per-voice costs; this is always before the next tick.

done[v] pulses in the MIX cycle of the last sample; busy[v] falls on the next cycle.

rom_addr holds its last value when rom_rd=0.

Reset asserted mid-scan:
- Discards the in-progress sample.
- Next cycle all outputs are at reset values.

## Configuration
- SOUND_SCHED_LOOP_EN defined: the loop input is honored as described.
- Not defined: loop is ignored, every voice is one-shot, and the loop port remains but is unused.

## Test plan
- Idle after reset, VOICES=4, DIV=3000: no inputs -> audio_strobe every 3000 cycles; audio=16'h8000; rom_rd never high.
- trig[0], start_addr=16'h0100, length=3, ROM bytes 8'h00/8'hFF/8'h80:
  - Three strobes -> audio 16'h6000, 16'h9FC0, 16'h8000.
  - rom_addr 0100/0101/0102; done[0] on third fetch; busy[0] low afterwards.
- Loop (macro defined), trig[1] with length=2 and loop=1: addresses alternate base, base+1 for 6 ticks; done[1] never pulses.
  - Same stimulus without the macro: voice ends after 2 ticks with a done pulse.
- Simultaneous events:
  - trig[2] and stop[2] in one tick window -> busy[2] stays 0.
  - trig[3] with length=0 -> ignored.
  - Restart of a busy voice -> next fetch at base.
- Wrap-around: start_addr=16'hFFFF, length=2 -> fetches at FFFF then 0000.
- Reset: assert reset during WAIT of voice 1 -> next cycle busy=0, audio=16'h8000, FSM in IDLE, first tick DIV-1 cycles after release.
